// File: rtl/seq_pkg.sv
// Shared opcode, state and instruction-field definitions for the instruction
// sequencer; the control unit imports the same opcode constants.
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_EQ   = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    HALT  = 2'b11
  } seq_state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 8;
  localparam int SRC_HI = 7;
  localparam int SRC_LO = 4;

  // Opcodes 1100..1110 fall outside this range and behave as NOPs.
  function automatic logic is_issued(input logic [3:0] op);
    return (op >= OP_MOV) && (op <= OP_EQ);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ISSUE-state timeout counter: cleared on ISSUE entry, counts stalled cycles
// and saturates at TIMEOUT-1, where expired is raised.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r == CW'(TIMEOUT - 1));

  // Stall counter with clear priority and saturation at the expiry value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch-and-issue sequencer: fetches 16-bit words, issues decoded
// opcodes until exec_done. Optional ISSUE watchdog under SEQ_TIMEOUT_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        dst,
  output logic [3:0]        src,
  output logic              issue_valid,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  seq_state_t        state_r, next_state_s;
  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [15:0]       ir_r, ir_next_s;
  logic              fault_r, fault_next_s;
  logic              wd_expired_s;
  logic              unused_s;

  assign pc        = pc_r;
  assign imem_addr = pc_r;
  assign fault     = fault_r;

`ifdef SEQ_TIMEOUT_EN
  logic wd_clear_s;
  logic wd_enable_s;

  assign wd_clear_s  = (next_state_s == ISSUE) && (state_r != ISSUE);
  assign wd_enable_s = (state_r == ISSUE) && !exec_done;
  assign unused_s    = ^ir_r[3:0];

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );
`else
  assign wd_expired_s = 1'b0;
  assign unused_s     = ^{ir_r[3:0], 32'(TIMEOUT)};
`endif

  // Next-state, program counter, instruction register and fault decisions.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = pc_r;
    ir_next_s    = ir_r;
    fault_next_s = fault_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = FETCH;
        else       next_state_s = IDLE;
      end
      FETCH: begin
        if (imem_valid) begin
          ir_next_s = imem_rdata;
          if (is_issued(imem_rdata[OPC_HI:OPC_LO])) begin
            next_state_s = ISSUE;
          end else if (imem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
            next_state_s = HALT;
          end else begin
            pc_next_s    = pc_r + ADDR_W'(1);
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = FETCH;
        end
      end
      ISSUE: begin
        // Completion wins over a simultaneous watchdog expiry.
        if (exec_done) begin
          pc_next_s    = pc_r + ADDR_W'(1);
          next_state_s = FETCH;
        end else if (wd_expired_s) begin
          fault_next_s = 1'b1;
          next_state_s = HALT;
        end else begin
          next_state_s = ISSUE;
        end
      end
      HALT: begin
        if (start) begin
          pc_next_s    = {ADDR_W{1'b0}};
          fault_next_s = 1'b0;
          next_state_s = FETCH;
        end else begin
          next_state_s = HALT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State registers and outputs, registered from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= {ADDR_W{1'b0}};
      ir_r        <= 16'h0000;
      fault_r     <= 1'b0;
      imem_req    <= 1'b0;
      opcode      <= OP_NOP;
      dst         <= 4'h0;
      src         <= 4'h0;
      issue_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      pc_r        <= pc_next_s;
      ir_r        <= ir_next_s;
      fault_r     <= fault_next_s;
      imem_req    <= (next_state_s == FETCH);
      issue_valid <= (next_state_s == ISSUE);
      halted      <= (next_state_s == HALT);
      opcode      <= (next_state_s == ISSUE) ? ir_next_s[OPC_HI:OPC_LO] : OP_NOP;
      dst         <= (next_state_s == ISSUE) ? ir_next_s[DST_HI:DST_LO] : 4'h0;
      src         <= (next_state_s == ISSUE) ? ir_next_s[SRC_HI:SRC_LO] : 4'h0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected issues are queued when the
// fetch response is driven and checked when issue_valid rises.
module tb_instr_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] dst;
    logic [3:0] src;
    logic [7:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = 16'h0000;
  logic              imem_valid = 1'b0;
  logic [3:0]        opcode, dst, src;
  logic              issue_valid;
  logic              exec_done = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;

  exp_t exp_q[$];
  exp_t exp_item;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic iv_prev  = 1'b0;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .opcode(opcode), .dst(dst), .src(src), .issue_valid(issue_valid),
    .exec_done(exec_done), .pc(pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] all_outs();
    return {imem_req, imem_addr, opcode, dst, src, issue_valid, pc, halted, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising edge of issue_valid must match the queue head.
  always @(negedge clk) begin
    if (issue_valid && !iv_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: got op=%h dst=%h src=%h pc=%0d, expected no issue", opcode, dst, src, pc);
      end else begin
        exp_item = exp_q.pop_front();
        if ({opcode, dst, src, pc} !== exp_item) begin
          n_fails++;
          $display("FAIL sb_issue: got %h, expected %h", {opcode, dst, src, pc}, exp_item);
        end
      end
    end
    iv_prev = issue_valid;
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_valid = 1'b0; exec_done = 1'b0; imem_rdata = 16'h0000;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; imem_valid = 1'b0; exec_done = 1'b0;
    tick(); tick();
    n_checks++; if (all_outs() !== 32'h0) begin n_fails++; $display("FAIL reset_outs: got %h, expected 0", all_outs()); end
    rst = 1'b0;
    tick();
    n_checks++; if (all_outs() !== 32'h0) begin n_fails++; $display("FAIL idle_outs: got %h, expected 0", all_outs()); end
  endtask

  task automatic test_basic();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 8'd0}) begin n_fails++; $display("FAIL start_fetch: got %h, expected 100", {imem_req, imem_addr}); end
    repeat (3) begin
      tick();
      n_checks++; if ({imem_req, issue_valid} !== 2'b10) begin n_fails++; $display("FAIL fetch_wait: got %b, expected 10", {imem_req, issue_valid}); end
    end
    imem_valid = 1'b1; imem_rdata = 16'h2120;
    exp_q.push_back({4'h2, 4'h1, 4'h2, 8'd0});
    tick();
    imem_rdata = 16'hFFFF;
    repeat (3) begin
      n_checks++; if ({issue_valid, imem_req, opcode, dst, src} !== {2'b10, 12'h212}) begin n_fails++; $display("FAIL issue_hold: got %h, expected 212 with issue_valid=1", {issue_valid, imem_req, opcode, dst, src}); end
      tick();
    end
    imem_valid = 1'b0; exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    n_checks++; if ({issue_valid, opcode, imem_req, pc, imem_addr} !== {1'b0, 4'h0, 1'b1, 8'd1, 8'd1}) begin n_fails++; $display("FAIL after_done: got %h, expected 1/pc=1", {issue_valid, opcode, imem_req, pc, imem_addr}); end
  endtask

  task automatic test_nop_halt();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h0000;
    tick();
    n_checks++; if ({issue_valid, opcode, imem_req, pc} !== {1'b0, 4'h0, 1'b1, 8'd1}) begin n_fails++; $display("FAIL nop_skip: got %h, expected pc=1 fetching", {issue_valid, opcode, imem_req, pc}); end
    imem_rdata = 16'hF000;
    tick();
    imem_valid = 1'b0;
    n_checks++; if ({halted, imem_req, issue_valid, opcode, pc} !== {3'b100, 4'h0, 8'd1}) begin n_fails++; $display("FAIL halt_state: got %h, expected halted pc=1", {halted, imem_req, issue_valid, opcode, pc}); end
    tick();
    n_checks++; if ({halted, pc} !== {1'b1, 8'd1}) begin n_fails++; $display("FAIL halt_stay: got %h, expected halted pc=1", {halted, pc}); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({halted, imem_req, pc, imem_addr, fault} !== {2'b01, 8'd0, 8'd0, 1'b0}) begin n_fails++; $display("FAIL restart: got %h, expected refetch at 0", {halted, imem_req, pc, imem_addr, fault}); end
  endtask

  task automatic test_wrap();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h0000;
    repeat (255) tick();
    n_checks++; if ({imem_req, pc} !== {1'b1, 8'd255}) begin n_fails++; $display("FAIL reach_255: got %h, expected fetch pc=255", {imem_req, pc}); end
    imem_rdata = 16'h3000;
    exp_q.push_back({4'h3, 4'h0, 4'h0, 8'd255});
    tick();
    imem_valid = 1'b0;
    n_checks++; if ({issue_valid, opcode, pc} !== {1'b1, 4'h3, 8'd255}) begin n_fails++; $display("FAIL issue_255: got %h, expected sub at 255", {issue_valid, opcode, pc}); end
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    n_checks++; if ({imem_req, pc, imem_addr, issue_valid} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin n_fails++; $display("FAIL pc_wrap: got %h, expected fetch at 0", {imem_req, pc, imem_addr, issue_valid}); end
  endtask

  task automatic test_reset_mid_fetch();
    n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("FAIL pre_rst_fetch: got %b, expected 1", imem_req); end
    imem_valid = 1'b1; imem_rdata = 16'h2120; rst = 1'b1;
    tick();
    rst = 1'b0; imem_valid = 1'b0;
    n_checks++; if (all_outs() !== 32'h0) begin n_fails++; $display("FAIL rst_fetch: got %h, expected 0", all_outs()); end
    tick();
    n_checks++; if (all_outs() !== 32'h0) begin n_fails++; $display("FAIL rst_fetch_idle: got %h, expected 0", all_outs()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exec_done = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h1340;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({imem_req, issue_valid, pc} !== {2'b10, 8'(i)}) begin n_fails++; $display("FAIL b2b_fetch: got %h, expected fetch pc=%0d", {imem_req, issue_valid, pc}, i); end
      exp_q.push_back({4'h1, 4'h3, 4'h4, 8'(i)});
      tick();
      n_checks++; if ({issue_valid, imem_req, opcode} !== {2'b10, 4'h1}) begin n_fails++; $display("FAIL b2b_issue: got %h, expected issue mov", {issue_valid, imem_req, opcode}); end
      tick();
    end
    n_checks++; if ({issue_valid, pc} !== {1'b0, 8'd4}) begin n_fails++; $display("FAIL b2b_end: got %h, expected pc=4", {issue_valid, pc}); end
    imem_valid = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'h2120;
    exp_q.push_back({4'h2, 4'h1, 4'h2, 8'd0});
    tick();
    imem_valid = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      n_checks++; if ({issue_valid, fault} !== 2'b10) begin n_fails++; $display("FAIL wd_issue: got %b, expected 10 at cycle %0d", {issue_valid, fault}, i); end
      if (i < TIMEOUT - 1) tick();
    end
    tick();
    n_checks++; if ({fault, halted, issue_valid, pc} !== {3'b110, 8'd0}) begin n_fails++; $display("FAIL wd_fault: got %h, expected fault halted pc=0", {fault, halted, issue_valid, pc}); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if ({fault, halted, imem_req} !== 3'b001) begin n_fails++; $display("FAIL wd_clear: got %b, expected 001", {fault, halted, imem_req}); end
    imem_valid = 1'b1;
    exp_q.push_back({4'h2, 4'h1, 4'h2, 8'd0});
    tick();
    imem_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    n_checks++; if ({fault, halted, imem_req, pc} !== {3'b001, 8'd1}) begin n_fails++; $display("FAIL wd_done_wins: got %h, expected fetch pc=1 no fault", {fault, halted, imem_req, pc}); end
`else
    repeat (10) tick();
    n_checks++; if ({issue_valid, fault, halted} !== 3'b100) begin n_fails++; $display("FAIL no_wd_wait: got %b, expected 100", {issue_valid, fault, halted}); end
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    n_checks++; if ({fault, imem_req, pc} !== {2'b01, 8'd1}) begin n_fails++; $display("FAIL no_wd_done: got %h, expected fetch pc=1", {fault, imem_req, pc}); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nop_halt();
    test_wrap();
    test_reset_mid_fetch();
    test_back_to_back();
    test_timeout();
    tick(); tick();
    n_checks++; if (exp_q.size() != 0) begin n_fails++; $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
